// File: rtl/axi_line_master.sv
// rtl/axi_line_master.sv - cache line refill/writeback AXI burst master; LEVE_AXI_ERR_EN enables response error reporting
module axi_line_master #(
  parameter int BEATS = 4
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 REQ_VALID,
  output logic                 REQ_READY,
  input  logic                 REQ_WE,
  input  logic [31:0]          REQ_ADDR,
  input  logic [128*BEATS-1:0] REQ_WDATA,
  output logic                 RSP_VALID,
  output logic [128*BEATS-1:0] RSP_RDATA,
  output logic                 RSP_ERR,
  output logic                 ARVALID,
  input  logic                 ARREADY,
  output logic [31:0]          ARADDR,
  output logic [7:0]           ARLEN,
  output logic [2:0]           ARSIZE,
  output logic [1:0]           ARBURST,
  input  logic                 RVALID,
  output logic                 RREADY,
  input  logic [127:0]         RDATA,
  input  logic [1:0]           RRESP,
  input  logic                 RLAST,
  output logic                 AWVALID,
  input  logic                 AWREADY,
  output logic [31:0]          AWADDR,
  output logic [7:0]           AWLEN,
  output logic [2:0]           AWSIZE,
  output logic [1:0]           AWBURST,
  output logic                 WVALID,
  input  logic                 WREADY,
  output logic [127:0]         WDATA,
  output logic [15:0]          WSTRB,
  output logic                 WLAST,
  input  logic                 BVALID,
  output logic                 BREADY,
  input  logic [1:0]           BRESP
);

  localparam int LINE_W = 128 * BEATS;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  // Byte offset bits within one line; cleared so bursts start on a line boundary.
  localparam logic [31:0]      OFFSET_MASK = 32'(16 * BEATS - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT   = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_AW,
    S_W,
    S_B,
    S_RSP
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [31:0]        addr_q;
  logic [LINE_W-1:0]  wdata_q;
  logic [LINE_W-1:0]  rdata_q;
  logic [CNT_W-1:0]   beat;
  logic               last_beat;
  logic               r_fire;
  logic               w_fire;

  assign last_beat = (beat == LAST_BEAT);
  assign r_fire    = RVALID & RREADY;
  assign w_fire    = WVALID & WREADY;

  // Burst shape is fixed: whole line, 16-byte beats, incrementing.
  assign ARADDR  = addr_q;
  assign ARLEN   = 8'(BEATS - 1);
  assign ARSIZE  = 3'b100;
  assign ARBURST = 2'b01;
  assign AWADDR  = addr_q;
  assign AWLEN   = 8'(BEATS - 1);
  assign AWSIZE  = 3'b100;
  assign AWBURST = 2'b01;
  assign WDATA   = wdata_q[{beat, 7'd0} +: 128];
  assign WSTRB   = 16'hFFFF;
  assign WLAST   = WVALID & last_beat;
  assign RSP_RDATA = rdata_q;

  // State register.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs; every valid/ready is a pure function of the state.
  always_comb begin
    state_nxt = state;
    REQ_READY = 1'b0;
    ARVALID   = 1'b0;
    RREADY    = 1'b0;
    AWVALID   = 1'b0;
    WVALID    = 1'b0;
    BREADY    = 1'b0;
    RSP_VALID = 1'b0;
    case (state)
      S_IDLE: begin
        REQ_READY = 1'b1;
        if (REQ_VALID) state_nxt = REQ_WE ? S_AW : S_AR;
      end
      S_AR: begin
        ARVALID = 1'b1;
        if (ARREADY) state_nxt = S_R;
      end
      S_R: begin
        RREADY = 1'b1;
        if (RVALID && last_beat) state_nxt = S_RSP;
      end
      S_AW: begin
        AWVALID = 1'b1;
        if (AWREADY) state_nxt = S_W;
      end
      S_W: begin
        WVALID = 1'b1;
        if (WREADY && last_beat) state_nxt = S_B;
      end
      S_B: begin
        BREADY = 1'b1;
        if (BVALID) state_nxt = S_RSP;
      end
      S_RSP: begin
        RSP_VALID = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Capture the accepted request: line-aligned address and the writeback line.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      addr_q <= '0;
    end else if (REQ_VALID && REQ_READY) begin
      addr_q  <= REQ_ADDR & ~OFFSET_MASK;
      wdata_q <= REQ_WDATA;
    end
  end

  // Beat counter: restarts on entry to a data phase, steps on each data handshake.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      beat <= '0;
    end else if ((state != S_R && state_nxt == S_R) || (state != S_W && state_nxt == S_W)) begin
      beat <= '0;
    end else if (r_fire || w_fire) begin
      beat <= beat + 1'b1;
    end
  end

  // Refill assembly: each accepted read beat lands in its slice of the line.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      rdata_q <= '0;
    end else if (r_fire) begin
      rdata_q[{beat, 7'd0} +: 128] <= RDATA;
    end
  end

`ifdef LEVE_AXI_ERR_EN
  logic err_q;

  // Sticky error across the burst; dropped once the response has been presented.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      err_q <= 1'b0;
    end else if (state == S_RSP) begin
      err_q <= 1'b0;
    end else if (r_fire && (RRESP != 2'b00 || RLAST != last_beat)) begin
      err_q <= 1'b1;
    end else if (BVALID && BREADY && BRESP != 2'b00) begin
      err_q <= 1'b1;
    end
  end

  assign RSP_ERR = (state == S_RSP) & err_q;
`else
  logic unused_err_inputs;

  assign unused_err_inputs = ^{RRESP, RLAST, BRESP};
  assign RSP_ERR = 1'b0;
`endif

endmodule
